hazard_forward_unit: RTL
========================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 Rst_n  input  1  reset; asynchronous, active-low.
REQ-004 ID_valid  input  1  instruction in ID is real (not bubble).
REQ-005 ID_rs  input  REG_AW  ID source register A.
REQ-006 ID_rt  input  REG_AW  ID source register B.
REQ-007 ID_uses_rt  input  1  ID instruction reads rt as an operand.
REQ-008 ID_dst  input  REG_AW  resolved ID destination register.
REQ-009 ID_reg_write  input  1  ID instruction writes the register file.
REQ-010 ID_mem_read  input  1  ID instruction is a load.
REQ-011 Flush  input  1  branch/BTB mispredict; kill the ID instruction.
REQ-012 Fwd_A_sel  output  2  operand-A forward-mux select for the EX stage.
REQ-013 Fwd_B_sel  output  2  operand-B forward-mux select for the EX stage.
REQ-014 Stall  output  1  hold PC and IF/ID; insert a bubble into EX.
REQ-015 Stall_cnt  output  32  count of load-use stall cycles.

Function
REQ-016 Select encoding SHALL be: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result; 11 SHALL never be driven.
REQ-017 Unit SHALL keep shadow entries EX (valid, rs, rt, uses_rt, dst, reg_write, mem_read), MEM (valid, dst, reg_write) and WB (valid, dst, reg_write), advancing EX->MEM->WB on every edge.
REQ-018 On an edge, EX SHALL load the ID fields with valid = ID_valid & ~Stall & ~Flush; otherwise EX valid SHALL be 0 (bubble).
REQ-019 Fwd_A_sel/Fwd_B_sel SHALL be registered: computed from ID_rs/ID_rt against the current EX and MEM entries, presented one cycle later, aligned with the EX entry.
REQ-020 A match SHALL require entry valid, reg_write=1, dst != 0 and dst equal to the source register.
REQ-021 Current-EX match SHALL give 01; otherwise current-MEM match SHALL give 10; otherwise 00. The newer producer SHALL win.
REQ-022 Fwd_B_sel SHALL be 00 when ID_uses_rt=0.
REQ-023 FSM states RUN and LU_STALL; reset state RUN.
REQ-024 In RUN, Stall SHALL assert combinationally when ID_valid and EX is a valid load with dst != 0 and dst == ID_rs, or dst == ID_rt with ID_uses_rt; the next state SHALL be LU_STALL.
REQ-025 In LU_STALL, Stall SHALL be 0 and the FSM SHALL return to RUN unconditionally; the re-presented ID instruction SHALL then see the load in MEM (select 10).
REQ-026 Flush SHALL override Stall: with Flush=1, Stall SHALL be 0, the FSM SHALL stay in RUN, and the registered selects SHALL load 00.
REQ-027 During a stall cycle, the registered selects SHALL load 00 (bubble in EX).

Reset
REQ-028 On Rst_n low, all shadow valid bits SHALL clear, Fwd_A_sel/Fwd_B_sel SHALL be 00, Stall SHALL be 0, FSM SHALL be RUN and Stall_cnt SHALL be 0, immediately and without a clock.
REQ-029 Reset asserted mid-stall SHALL abort the stall; the first post-reset cycle SHALL show Stall=0.

Configuration
REQ-030 Macro HFU_STALL_CNT_EN: when defined, Stall_cnt SHALL increment by 1 on each edge with Stall=1 and saturate at 32'hFFFFFFFF.
REQ-031 When HFU_STALL_CNT_EN is undefined, Stall_cnt SHALL be constant 0 with no counter logic, and all other behaviour SHALL be unchanged.

Verification
REQ-032 add $3 then sub $5,$3,$4 back-to-back -> in sub's EX cycle Fwd_A_sel=01, Fwd_B_sel=00.
REQ-033 add $3, nop, or $6,$7,$3 -> in or's EX cycle Fwd_B_sel=10.
REQ-034 add $3, addi $3, then use $3 as rs -> Fwd_A_sel=01, not 10.
REQ-035 lw $4 then add $8,$9,$4 -> Stall=1 for exactly one cycle, bubble in EX, then Fwd_B_sel=10; Stall_cnt=1 (macro on) or 0 (macro off).
REQ-036 Writes to $0 followed by use of $0 -> selects stay 00; Flush in the same cycle as a load-use hazard -> Stall=0, FSM stays in RUN.
REQ-037 Rst_n pulsed low during LU_STALL -> outputs immediately at reset values; after release, no residual stall.

Source files
------------

// File: rtl/hfu_if.sv
// hfu_if: bundle between the decode stage and the hazard/forward unit.
//   master : decode side, drives the ID-stage instruction fields and flush,
//            receives the forward selects, stall and stall counter.
//   slave  : hazard_forward_unit side.
// Fields:
//   id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read,
//   flush                         -> unit
//   fwd_a_sel, fwd_b_sel (2b), stall, stall_cnt (32b) <- unit
interface hfu_if #(parameter int REG_AW = 5);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall;
  logic [31:0]       stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write,
           id_mem_read, flush,
    input  fwd_a_sel, fwd_b_sel, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write,
           id_mem_read, flush,
    output fwd_a_sel, fwd_b_sel, stall, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: data-hazard detection and operand forwarding for a
// classic 5-stage pipeline.
//   clk   : pipeline clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hfu_if.slave (ID fields + flush in; selects, stall, counter out)
// Keeps shadow copies of the EX, MEM and WB instructions. Selects are
// computed from the ID sources against EX/MEM and registered, so they line
// up with the instruction once it sits in EX (00 RF, 01 EX/MEM, 10 MEM/WB).
// A load in EX feeding the ID instruction stalls one cycle (RUN->LU_STALL).
// Optional feature macro: HFU_STALL_CNT_EN enables a saturating load-use
// stall counter on stall_cnt; without it stall_cnt is tied to 0.
module hazard_forward_unit #(
  parameter int REG_AW = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  hfu_if.slave   bus
);

  typedef enum logic {RUN, LU_STALL} state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  state_t state_q, state_d;

  // EX shadow entry
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic              ex_uses_rt_q, ex_uses_rt_d;
  logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
  logic              ex_rw_q, ex_rw_d;
  logic              ex_mr_q, ex_mr_d;
  // MEM shadow entry
  logic              mem_valid_q, mem_valid_d;
  logic [REG_AW-1:0] mem_dst_q, mem_dst_d;
  logic              mem_rw_q, mem_rw_d;
  // WB shadow entry
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_dst_q, wb_dst_d;
  logic              wb_rw_q, wb_rw_d;

  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  logic stall;
  logic lu_hazard;
  logic ex_prod, mem_prod;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

  // A stage is a forwarding producer only if it really writes a non-zero reg.
  assign ex_prod  = ex_valid_q  && ex_rw_q  && (ex_dst_q  != '0);
  assign mem_prod = mem_valid_q && mem_rw_q && (mem_dst_q != '0);

  assign ex_hit_a  = ex_prod  && (ex_dst_q  == bus.id_rs);
  assign ex_hit_b  = ex_prod  && (ex_dst_q  == bus.id_rt);
  assign mem_hit_a = mem_prod && (mem_dst_q == bus.id_rs);
  assign mem_hit_b = mem_prod && (mem_dst_q == bus.id_rt);

  // Load result is not available until MEM, so a consumer right behind it
  // must wait one cycle.
  assign lu_hazard = bus.id_valid && ex_valid_q && ex_mr_q && (ex_dst_q != '0) &&
                     ((ex_dst_q == bus.id_rs) ||
                      (bus.id_uses_rt && (ex_dst_q == bus.id_rt)));

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        // flush kills the consumer, so there is nothing to stall for
        if (lu_hazard && !bus.flush) begin
          stall   = 1'b1;
          state_d = LU_STALL;
        end
      end
      LU_STALL: state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    ex_valid_d   = bus.id_valid && !stall && !bus.flush;
    ex_rs_d      = bus.id_rs;
    ex_rt_d      = bus.id_rt;
    ex_uses_rt_d = bus.id_uses_rt;
    ex_dst_d     = bus.id_dst;
    ex_rw_d      = bus.id_reg_write;
    ex_mr_d      = bus.id_mem_read;
    mem_valid_d  = ex_valid_q;
    mem_dst_d    = ex_dst_q;
    mem_rw_d     = ex_rw_q;
    wb_valid_d   = mem_valid_q;
    wb_dst_d     = mem_dst_q;
    wb_rw_d      = mem_rw_q;

    // Newer producer (EX) wins over MEM.
    fwd_a_d = ex_hit_a ? SEL_EX : (mem_hit_a ? SEL_MEM : SEL_RF);
    fwd_b_d = !bus.id_uses_rt ? SEL_RF :
              (ex_hit_b ? SEL_EX : (mem_hit_b ? SEL_MEM : SEL_RF));
    // A bubble enters EX on stall or flush; it must not forward anything.
    if (stall || bus.flush) begin
      fwd_a_d = SEL_RF;
      fwd_b_d = SEL_RF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      ex_valid_q   <= 1'b0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_uses_rt_q <= 1'b0;
      ex_dst_q     <= '0;
      ex_rw_q      <= 1'b0;
      ex_mr_q      <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_dst_q    <= '0;
      mem_rw_q     <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_dst_q     <= '0;
      wb_rw_q      <= 1'b0;
      fwd_a_q      <= SEL_RF;
      fwd_b_q      <= SEL_RF;
    end else begin
      state_q      <= state_d;
      ex_valid_q   <= ex_valid_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_uses_rt_q <= ex_uses_rt_d;
      ex_dst_q     <= ex_dst_d;
      ex_rw_q      <= ex_rw_d;
      ex_mr_q      <= ex_mr_d;
      mem_valid_q  <= mem_valid_d;
      mem_dst_q    <= mem_dst_d;
      mem_rw_q     <= mem_rw_d;
      wb_valid_q   <= wb_valid_d;
      wb_dst_q     <= wb_dst_d;
      wb_rw_q      <= wb_rw_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
    end
  end

`ifdef HFU_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

  assign bus.fwd_a_sel = fwd_a_q;
  assign bus.fwd_b_sel = fwd_b_q;
  assign bus.stall     = stall;

endmodule
